// File: rtl/mcht_pkg.sv
// Shared types and header layout for the Manchester receive deframer.
package mcht_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAYLD,
        CKSUM,
        DISCARD
    } state_t;

    typedef enum logic [2:0] {
        STS_OK      = 3'd0,
        STS_SYNC    = 3'd1,
        STS_LEN     = 3'd2,
        STS_CKSUM   = 3'd3,
        STS_TIMEOUT = 3'd4,
        STS_OVF     = 3'd5
    } sts_code_t;

    localparam logic [3:0] MCHT_SYNC = 4'hA;

    // Header word: {sync[15:12], type[11:8], len[7:0]}
    localparam int HDR_SYNC_LSB = 12;
    localparam int HDR_SYNC_W   = 4;
    localparam int HDR_TYPE_LSB = 8;
    localparam int HDR_TYPE_W   = 4;
    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_LEN_W    = 8;

endpackage

// File: rtl/mcht_sfifo.sv
// Small synchronous FIFO with a show-ahead read port; a pop frees a slot
// for a push in the same cycle even when full.
module mcht_sfifo #(
    parameter int pWIDTH = 17,
    parameter int pDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [pWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [pWIDTH-1:0] out_data,
    output logic              out_vld,
    output logic              full
);

    localparam int AW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
    localparam int CW = AW + 1;

    logic [pWIDTH-1:0] mem [pDEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign out_vld  = (count != '0);
    assign full     = (count == CW'(pDEPTH));
    assign do_pop   = pop && out_vld;
    assign do_push  = push && (!full || do_pop);
    assign out_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < pDEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mcht_rx_deframer.sv
// Parses header/payload/checksum frames from the Manchester decoder, buffers
// payload for the consumer and reports one status pulse per frame.
module mcht_rx_deframer
    import mcht_pkg::*;
#(
    parameter int pMSG_LEN    = 16,
    parameter int pMAX_LEN    = 32,
    parameter int pFIFO_DEPTH = 4,
    parameter int pTIMEOUT    = 1024
) (
    input  logic                CLK_25M,
    input  logic                RST_N,
    input  logic [pMSG_LEN-1:0] RX_MSG,
    input  logic                RX_VLD,
    output logic [15:0]         OUT_DATA,
    output logic                OUT_VLD,
    input  logic                OUT_RDY,
    output logic                OUT_EOF,
    output logic                STS_VLD,
    output logic [2:0]          STS_CODE,
    output logic [3:0]          STS_TYPE,
    output logic [7:0]          ERR_CNT
);

    localparam int TW = $clog2(pTIMEOUT + 1);

    state_t    state_q, state_d;
    logic [3:0]  type_q, type_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] sum_q, sum_d;
    logic [TW-1:0] timer_q;

    logic [15:0] word;
    logic [3:0]  hdr_sync;
    logic [3:0]  hdr_type;
    logic [7:0]  hdr_len;
    logic        timed_out;
    logic        fifo_full;
    logic        push_ok;
    logic        push;
    logic        push_eof;
    logic [16:0] fifo_q;

    logic        ev_vld;
    sts_code_t   ev_code;
    logic [3:0]  ev_type;

    assign word     = RX_MSG[15:0];
    assign hdr_sync = word[HDR_SYNC_LSB +: HDR_SYNC_W];
    assign hdr_type = word[HDR_TYPE_LSB +: HDR_TYPE_W];
    assign hdr_len  = word[HDR_LEN_LSB +: HDR_LEN_W];

    // An arriving word always beats the idle timer in the same cycle.
    assign timed_out = (state_q != IDLE) && !RX_VLD && (timer_q == TW'(pTIMEOUT - 1));
    assign push_ok   = !fifo_full || (OUT_VLD && OUT_RDY);

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        ev_vld   = 1'b0;
        ev_code  = STS_OK;
        ev_type  = '0;
        push     = 1'b0;
        push_eof = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_VLD) begin
                    if (hdr_sync != MCHT_SYNC) begin
                        ev_vld  = 1'b1;
                        ev_code = STS_SYNC;
                    end else if (hdr_len == '0 || int'(hdr_len) > pMAX_LEN) begin
                        ev_vld  = 1'b1;
                        ev_code = STS_LEN;
                    end else begin
                        type_d  = hdr_type;
                        len_d   = hdr_len;
                        cnt_d   = '0;
                        sum_d   = word;
                        state_d = PAYLD;
                    end
                end
            end
            PAYLD: begin
                if (RX_VLD) begin
                    cnt_d = cnt_q + 8'd1;
                    sum_d = sum_q + word;
                    if (!push_ok) begin
                        state_d = DISCARD;
                    end else begin
                        push     = 1'b1;
                        push_eof = (cnt_q + 8'd1 == len_q);
                        if (cnt_q + 8'd1 == len_q) begin
                            state_d = CKSUM;
                        end
                    end
                end
            end
            CKSUM: begin
                if (RX_VLD) begin
                    ev_vld  = 1'b1;
                    ev_code = (word == sum_q) ? STS_OK : STS_CKSUM;
                    ev_type = type_q;
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                // Once cnt reaches len the next word is the checksum.
                if (RX_VLD) begin
                    if (cnt_q == len_q) begin
                        ev_vld  = 1'b1;
                        ev_code = STS_OVF;
                        ev_type = type_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timed_out) begin
            ev_vld  = 1'b1;
            ev_code = STS_TIMEOUT;
            ev_type = type_q;
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK_25M) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            type_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            timer_q  <= '0;
            STS_VLD  <= 1'b0;
            STS_CODE <= '0;
            STS_TYPE <= '0;
            ERR_CNT  <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            timer_q <= (RX_VLD || state_q == IDLE || timed_out) ? '0 : timer_q + TW'(1);
            STS_VLD <= ev_vld;
            if (ev_vld) begin
                STS_CODE <= ev_code;
                STS_TYPE <= ev_type;
                if (ev_code != STS_OK && ERR_CNT != 8'hFF) begin
                    ERR_CNT <= ERR_CNT + 8'd1;
                end
            end
        end
    end

    mcht_sfifo #(
        .pWIDTH (17),
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK_25M),
        .rst_n     (RST_N),
        .push      (push),
        .push_data ({push_eof, word}),
        .pop       (OUT_RDY),
        .out_data  (fifo_q),
        .out_vld   (OUT_VLD),
        .full      (fifo_full)
    );

    assign OUT_DATA = fifo_q[15:0];
    assign OUT_EOF  = fifo_q[16] & OUT_VLD;

endmodule

// File: tb/tb_mcht_rx_deframer.sv
// Scoreboard bench for mcht_rx_deframer: frame-level reference model feeds
// expected words/statuses into queues that a negedge monitor drains.
`timescale 1ns/1ps
module tb_mcht_rx_deframer;
    import mcht_pkg::*;

    localparam int DEPTH  = 4;
    localparam int MAXLEN = 32;
    localparam int TMO    = 1024;

    logic        CLK_25M = 1'b0;
    logic        RST_N   = 1'b0;
    logic [15:0] RX_MSG  = '0;
    logic        RX_VLD  = 1'b0;
    logic [15:0] OUT_DATA;
    logic        OUT_VLD;
    logic        OUT_RDY = 1'b0;
    logic        OUT_EOF;
    logic        STS_VLD;
    logic [2:0]  STS_CODE;
    logic [3:0]  STS_TYPE;
    logic [7:0]  ERR_CNT;

    typedef struct packed {logic eof; logic [15:0] data;} exp_word_t;
    typedef struct packed {logic [2:0] code; logic [3:0] ftype;} exp_sts_t;

    exp_word_t exp_data[$];
    exp_sts_t  exp_sts[$];
    int checks = 0;
    int errors = 0;
    int occ = 0;
    int errs_model = 0;
    logic [15:0] pl [MAXLEN];

    mcht_rx_deframer dut (
        .CLK_25M  (CLK_25M),
        .RST_N    (RST_N),
        .RX_MSG   (RX_MSG),
        .RX_VLD   (RX_VLD),
        .OUT_DATA (OUT_DATA),
        .OUT_VLD  (OUT_VLD),
        .OUT_RDY  (OUT_RDY),
        .OUT_EOF  (OUT_EOF),
        .STS_VLD  (STS_VLD),
        .STS_CODE (STS_CODE),
        .STS_TYPE (STS_TYPE),
        .ERR_CNT  (ERR_CNT)
    );

    always #20 CLK_25M = ~CLK_25M;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: drains the scoreboard whenever the DUT presents output.
    exp_word_t   mon_w;
    exp_sts_t    mon_s;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_out   = '0;

    always @(negedge CLK_25M) begin
        if (!RST_N) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_vld", 32'(OUT_VLD), 32'd1);
                checkOutput("hold_data", 32'({OUT_EOF, OUT_DATA}), 32'(prev_out));
            end
            if (OUT_VLD && OUT_RDY) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got %0h, expected none", {OUT_EOF, OUT_DATA});
                end else begin
                    mon_w = exp_data.pop_front();
                    checkOutput("out_word", 32'({OUT_EOF, OUT_DATA}), 32'(mon_w));
                end
            end
            if (STS_VLD) begin
                if (exp_sts.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_status: got code %0d type %0h, expected none", STS_CODE, STS_TYPE);
                end else begin
                    mon_s = exp_sts.pop_front();
                    checkOutput("status", 32'({STS_CODE, STS_TYPE}), 32'(mon_s));
                end
            end
            prev_stall = OUT_VLD && !OUT_RDY;
            prev_out   = {OUT_EOF, OUT_DATA};
        end
    end

    function automatic logic pickRdy(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // One clock of stimulus; the occupancy count decides whether a payload
    // word fits (a same-cycle pop frees a slot).
    task automatic applyStimulus(input logic vld, input logic [15:0] msg, input logic rdy,
                                 input logic want_push, input logic eof, output logic accepted);
        logic pop;
        RX_VLD  = vld;
        RX_MSG  = msg;
        OUT_RDY = rdy;
        pop      = (occ > 0) && rdy;
        accepted = want_push && ((occ < DEPTH) || pop);
        if (accepted) exp_data.push_back({eof, msg});
        occ = occ - int'(pop) + int'(accepted);
        @(posedge CLK_25M);
        #1;
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        applyStimulus(1'b0, 16'($urandom), rdy, 1'b0, 1'b0, acc);
    endtask

    task automatic gapCycles(input int gap_max, input int rdy_mode);
        int n;
        n = $urandom_range(0, gap_max);
        for (int i = 0; i < n; i++) idle(pickRdy(rdy_mode));
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 4; i++) idle(1'b1);
    endtask

    task automatic expectStatus(input sts_code_t code, input logic [3:0] ftype);
        exp_sts_t s;
        s.code  = code;
        s.ftype = ftype;
        exp_sts.push_back(s);
        if (code != STS_OK && errs_model < 255) errs_model++;
    endtask

    // ck_mode: 0 correct checksum, 1 corrupted, 2 fixed_ck, 3 checksum never sent
    task automatic sendFrame(input logic [15:0] hdr, input int npl, input int ck_mode,
                             input logic [15:0] fixed_ck, input int gap_max, input int rdy_mode);
        int          len;
        logic [15:0] sum;
        logic [15:0] ck;
        logic        dropped;
        logic        acc;
        logic        bad;
        len = int'(hdr[7:0]);
        bad = 1'b1;
        if (hdr[15:12] != MCHT_SYNC) expectStatus(STS_SYNC, 4'h0);
        else if (len == 0 || len > MAXLEN) expectStatus(STS_LEN, 4'h0);
        else bad = 1'b0;
        applyStimulus(1'b1, hdr, pickRdy(rdy_mode), 1'b0, 1'b0, acc);
        if (bad) return;
        sum     = hdr;
        dropped = 1'b0;
        for (int i = 0; i < npl && i < len; i++) begin
            gapCycles(gap_max, rdy_mode);
            sum = sum + pl[i];
            applyStimulus(1'b1, pl[i], pickRdy(rdy_mode), !dropped, (i == len - 1), acc);
            if (!dropped && !acc) dropped = 1'b1;
        end
        if (npl < len || ck_mode == 3) begin
            expectStatus(STS_TIMEOUT, hdr[11:8]);
            return;
        end
        case (ck_mode)
            0:       ck = sum;
            1:       ck = sum + 16'($urandom_range(1, 65535));
            default: ck = fixed_ck;
        endcase
        gapCycles(gap_max, rdy_mode);
        if (dropped) expectStatus(STS_OVF, hdr[11:8]);
        else if (ck == sum) expectStatus(STS_OK, hdr[11:8]);
        else expectStatus(STS_CKSUM, hdr[11:8]);
        applyStimulus(1'b1, ck, pickRdy(rdy_mode), 1'b0, 1'b0, acc);
    endtask

    initial begin
        #6000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        acc;
        int          kind;
        int          len;
        int          npl;
        int          ck_mode;
        logic [3:0]  sync;
        logic [3:0]  ty;
        logic [15:0] hdr;

        // Reset state
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b0);
        checkOutput("rst_out_vld", 32'(OUT_VLD), 32'd0);
        checkOutput("rst_out_eof", 32'(OUT_EOF), 32'd0);
        checkOutput("rst_out_data", 32'(OUT_DATA), 32'd0);
        checkOutput("rst_sts_vld", 32'(STS_VLD), 32'd0);
        checkOutput("rst_sts_code", 32'(STS_CODE), 32'd0);
        checkOutput("rst_sts_type", 32'(STS_TYPE), 32'd0);
        checkOutput("rst_err_cnt", 32'(ERR_CNT), 32'd0);
        RST_N = 1'b1;
        idle(1'b1);

        // Good frame, then the same frame with a bad checksum
        pl[0] = 16'h0001; pl[1] = 16'h0002; pl[2] = 16'h0003;
        sendFrame(16'hA103, 3, 2, 16'hA109, 0, 0);
        drain();
        sendFrame(16'hA103, 3, 2, 16'hA10A, 0, 0);
        drain();
        checkOutput("err_cnt_cksum", 32'(ERR_CNT), 32'd1);

        // Bad sync and bad length headers report on the very next cycle
        expectStatus(STS_SYNC, 4'h0);
        applyStimulus(1'b1, 16'h5102, 1'b1, 1'b0, 1'b0, acc);
        checkOutput("sync_next_cycle", 32'(STS_VLD), 32'd1);
        idle(1'b1);
        checkOutput("sync_no_push", 32'(OUT_VLD), 32'd0);
        expectStatus(STS_LEN, 4'h0);
        applyStimulus(1'b1, 16'hA100, 1'b1, 1'b0, 1'b0, acc);
        checkOutput("len_next_cycle", 32'(STS_VLD), 32'd1);
        idle(1'b1);
        checkOutput("len_no_push", 32'(OUT_VLD), 32'd0);

        // Overflow with a stalled consumer, then an intact frame
        for (int i = 0; i < 6; i++) pl[i] = 16'(16'h0100 + i);
        sendFrame(16'hA206, 6, 0, 16'h0000, 0, 1);
        idle(1'b0);
        checkOutput("ovf_buffered", 32'(OUT_VLD), 32'd1);
        drain();
        for (int i = 0; i < 3; i++) pl[i] = 16'($urandom);
        sendFrame(16'hA203, 3, 0, 16'h0000, 1, 2);
        drain();

        // Timeout exactly at expiry
        expectStatus(STS_TIMEOUT, 4'h5);
        applyStimulus(1'b1, 16'hA502, 1'b1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, acc);
        for (int i = 0; i < TMO - 1; i++) idle(1'b1);
        checkOutput("tmo_not_early", 32'(STS_VLD), 32'd0);
        idle(1'b1);
        checkOutput("tmo_at_expiry", 32'(STS_VLD), 32'd1);
        drain();

        // A word in the expiry cycle wins over the timer
        applyStimulus(1'b1, 16'hA502, 1'b1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, acc);
        for (int i = 0; i < TMO - 1; i++) idle(1'b1);
        applyStimulus(1'b1, 16'h2222, 1'b1, 1'b1, 1'b1, acc);
        checkOutput("tmo_word_wins", 32'(STS_VLD), 32'd0);
        expectStatus(STS_OK, 4'h5);
        applyStimulus(1'b1, 16'hA502 + 16'h1111 + 16'h2222, 1'b1, 1'b0, 1'b0, acc);
        drain();

        // Randomized frames
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 99);
            ty   = 4'($urandom);
            len  = $urandom_range(1, MAXLEN);
            sync = MCHT_SYNC;
            npl  = len;
            ck_mode = 0;
            for (int i = 0; i < MAXLEN; i++) pl[i] = 16'($urandom);
            if (kind < 8) begin
                sync = 4'($urandom_range(0, 15));
                if (sync == MCHT_SYNC) sync = 4'h5;
            end else if (kind < 16) begin
                len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(MAXLEN + 1, 255);
            end else if (kind < 20) begin
                npl = $urandom_range(0, len - 1);
            end else if (kind < 22) begin
                ck_mode = 3;
            end else if (kind < 34) begin
                ck_mode = 1;
            end
            hdr = {sync, ty, 8'(len)};
            sendFrame(hdr, npl, ck_mode, 16'h0000, $urandom_range(0, 3), $urandom_range(0, 2));
            if (sync == MCHT_SYNC && len >= 1 && len <= MAXLEN && (npl < len || ck_mode == 3)) begin
                for (int i = 0; i < TMO + 3; i++) idle(pickRdy(2));
            end else begin
                gapCycles(4, 2);
            end
        end
        drain();
        checkOutput("rand_err_cnt", 32'(ERR_CNT), 32'(errs_model));
        checkOutput("rand_sts_drained", 32'(exp_sts.size()), 32'd0);
        checkOutput("rand_data_drained", 32'(exp_data.size()), 32'd0);

        // Reset mid-payload drops the partial frame silently
        applyStimulus(1'b1, 16'hA704, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 16'h0AAA, 1'b0, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 16'h0BBB, 1'b0, 1'b1, 1'b0, acc);
        RST_N = 1'b0;
        idle(1'b0);
        RST_N = 1'b1;
        exp_data.delete();
        occ = 0;
        errs_model = 0;
        checkOutput("midrst_out_vld", 32'(OUT_VLD), 32'd0);
        checkOutput("midrst_err_cnt", 32'(ERR_CNT), 32'd0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        checkOutput("midrst_no_sts", 32'(STS_VLD), 32'd0);
        for (int i = 0; i < 4; i++) pl[i] = 16'($urandom);
        sendFrame(16'hA904, 4, 0, 16'h0000, 1, 0);
        drain();

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            if (i % 2 == 0) begin
                expectStatus(STS_SYNC, 4'h0);
                applyStimulus(1'b1, 16'h5102, 1'b1, 1'b0, 1'b0, acc);
            end else begin
                expectStatus(STS_LEN, 4'h0);
                applyStimulus(1'b1, 16'hA100, 1'b1, 1'b0, 1'b0, acc);
            end
        end
        drain();
        checkOutput("err_cnt_saturated", 32'(ERR_CNT), 32'h0000_00FF);
        checkOutput("final_sts_drained", 32'(exp_sts.size()), 32'd0);
        checkOutput("final_data_drained", 32'(exp_data.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcht_rx_deframer.md
MCHT_RX_DEFRAMER -- requirements
Module: mcht_rx_deframer

Interface
REQ-001 Parameters SHALL be: pMSG_LEN, default 16, decoder word width (fixed at 16 in this release); pMAX_LEN, default 32, maximum payload words per frame; pFIFO_DEPTH, default 4, power of two, output buffer depth; pTIMEOUT, default 1024, maximum idle cycles between words inside a frame.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK_25M  in  1  single clock; one clock; all logic on its rising edge
- RST_N  in  1  reset, synchronous, active-low
- RX_MSG  in  pMSG_LEN  word from Manchester decoder
- RX_VLD  in  1  one-cycle strobe, RX_MSG valid; no backpressure possible
- OUT_DATA  out  16  payload word
- OUT_VLD  out  1  OUT_DATA valid
- OUT_RDY  in  1  consumer accepts; transfer when OUT_VLD & OUT_RDY
- OUT_EOF  out  1  qualifies last payload word of a frame
- STS_VLD  out  1  one-cycle frame-status pulse
- STS_CODE  out  3  0 OK, 1 SYNC, 2 LEN, 3 CKSUM, 4 TIMEOUT, 5 OVF
- STS_TYPE  out  4  type field of the frame reported
- ERR_CNT  out  8  saturating count of non-OK statuses

Function
REQ-003 Frame format SHALL be: header word {sync[15:12]=4'hA, type[11:8], len[7:0]}, then len payload words, then one checksum word.
REQ-004 Checksum SHALL equal the sum mod 2^16 of the header and all payload words.
REQ-005 FSM states SHALL be IDLE, PAYLD, CKSUM and DISCARD.
REQ-006 IDLE + RX_VLD: sync != 4'hA -> STS_CODE=1, stay IDLE; len==0 or len>pMAX_LEN -> STS_CODE=2, stay IDLE; otherwise latch type/len, seed sum, -> PAYLD.
REQ-007 PAYLD + RX_VLD SHALL push the word into the FIFO, tagging EOF on word len, accumulating the sum; after word len -> CKSUM.
REQ-008 CKSUM + RX_VLD: match -> STS_CODE=0, mismatch -> STS_CODE=3; -> IDLE either way.
REQ-009 Each status SHALL drive STS_VLD high for exactly the one cycle after the RX_VLD that caused it, with STS_TYPE valid that cycle (0 for SYNC/LEN errors).
REQ-010 Payload already pushed SHALL NOT be retracted on CKSUM error; the consumer discards on non-OK status.
REQ-011 A push with the FIFO full (occupancy == pFIFO_DEPTH and no same-cycle pop) SHALL drop the word and go to DISCARD; DISCARD SHALL count the remaining payload words and checksum without pushing, then report STS_CODE=5 and -> IDLE.
REQ-012 A push and a pop in the same cycle with the FIFO full SHALL both succeed.
REQ-013 In PAYLD, CKSUM or DISCARD, pTIMEOUT cycles without RX_VLD SHALL report STS_CODE=4 and -> IDLE; the timer SHALL restart on every RX_VLD, and RX_VLD in the expiry cycle SHALL win.
REQ-014 OUT_VLD SHALL assert the cycle after the first push into an empty FIFO; OUT_DATA and OUT_EOF SHALL hold stable while OUT_VLD & !OUT_RDY.
REQ-015 ERR_CNT SHALL increment on each non-OK STS_VLD and saturate at 8'hFF.

Reset
REQ-016 With RST_N low at a clock edge: state=IDLE; FIFO emptied; OUT_VLD, OUT_EOF, STS_VLD=0; OUT_DATA, STS_CODE, STS_TYPE, ERR_CNT, sum, timer=0.
REQ-017 Reset mid-frame SHALL drop the partial frame with no status; the first RX_VLD after release SHALL be parsed as a header.

Structure
REQ-018 Package mcht_pkg SHALL hold the FSM state enum, the status-code enum, the MCHT_SYNC constant 4'hA and header field positions.
REQ-019 The output buffer SHALL be a sub-module mcht_sfifo (width 17 = EOF + data, depth pFIFO_DEPTH), with the same clock and reset.

Verification
REQ-020 Frame 16'hA103, 0001, 0002, 0003, cksum 16'hA109, OUT_RDY=1 -> three words out, EOF on 0003; STS_VLD with CODE=0, TYPE=1.
REQ-021 Same frame with checksum 16'hA10A -> three words out; STS CODE=3; ERR_CNT=1.
REQ-022 Header 16'h5102 -> STS CODE=1 the next cycle, nothing pushed; header 16'hA100 -> CODE=2.
REQ-023 OUT_RDY=0, frame len=6 with depth 4 -> four words buffered, DISCARD entered, STS CODE=5 after the checksum; the next valid frame is received intact.
REQ-024 Header len=2, one payload word, then silence of 1024 cycles -> STS CODE=4 exactly at expiry; a word arriving on cycle 1024 -> no timeout.
REQ-025 RST_N low for one cycle mid-payload -> no STS_VLD, FIFO empty, next header parsed normally; 260 bad headers -> ERR_CNT=8'hFF.
